// File: rtl/msub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msub_pkg
// Purpose  : Shared types and width helpers for the multi-byte subtract
//            sequencer (multibyte_sub_ctrl) and its byte slice.
// Contents : msub_state_e      - sequencer state encoding (IDLE, RUN, DONE)
//            msub_width()      - full operand width for a slice/byte count
//            msub_idx_width()  - byte-index counter width, never below 1 bit
// Revision : 1.0  initial release
// ============================================================================
package msub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } msub_state_e;

   // Total operand width in bits.
   function automatic int msub_width(input int dw, input int nb);
      return dw * nb;
   endfunction

   // A single-byte build still needs a 1-bit index so the counter exists.
   function automatic int msub_idx_width(input int nb);
      return (nb <= 1) ? 1 : $clog2(nb);
   endfunction

endpackage : msub_pkg
`default_nettype wire

// File: rtl/msub_byte_slice.sv
`default_nettype none
// ============================================================================
// Module   : msub_byte_slice
// Purpose  : Combinational DATA_WIDTH-bit subtractor a - b - borrow_in.
//            One instance is time-shared across all byte positions.
// Ports    : a_i          in  DATA_WIDTH  minuend slice
//            b_i          in  DATA_WIDTH  subtrahend slice
//            borrow_i     in  1           borrow from the lower slice
//            diff_o       out DATA_WIDTH  difference modulo 2^DATA_WIDTH
//            borrow_o     out 1           borrow into the next slice
// Revision : 1.0  initial release
// ============================================================================
module msub_byte_slice #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  borrow_i,
   output logic [DATA_WIDTH-1:0] diff_o,
   output logic                  borrow_o
);

   // One extra bit: after a zero-extended subtract the top bit is set
   // exactly when the true result went negative, i.e. a borrow occurred.
   logic [DATA_WIDTH:0] ext_diff_w;

   assign ext_diff_w = {1'b0, a_i} - {1'b0, b_i} - {{DATA_WIDTH{1'b0}}, borrow_i};
   assign diff_o     = ext_diff_w[DATA_WIDTH-1:0];
   assign borrow_o   = ext_diff_w[DATA_WIDTH];

endmodule : msub_byte_slice
`default_nettype wire

// File: rtl/multibyte_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multibyte_sub_ctrl
// Purpose  : Sequencer computing a NUM_BYTES*DATA_WIDTH-bit A - B - borrow_in
//            one byte per cycle, least-significant byte first, through a
//            single shared msub_byte_slice. Borrow is chained in a register.
// Ports    : clk          in  1  clock, rising edge
//            rst_n        in  1  asynchronous active-low reset
//            start        in  1  request, sampled only in IDLE
//            op_a         in  W  minuend, captured on accept
//            op_b         in  W  subtrahend, captured on accept
//            borrow_in    in  1  initial borrow, captured on accept
//            busy         out 1  high from the cycle after accept until done
//            done         out 1  one-cycle pulse, results valid with it
//            diff         out W  A - B - borrow_in modulo 2^W
//            borrow_out   out 1  borrow out of the most-significant byte
// Options  : MSUB_SATURATE_EN - when defined, a final borrow clamps diff to 0
//            (borrow_out still reports 1 so clamping is detectable).
// Revision : 1.0  initial release
// ============================================================================
module multibyte_sub_ctrl
   import msub_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_BYTES  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [DATA_WIDTH*NUM_BYTES-1:0] op_a,
   input  logic [DATA_WIDTH*NUM_BYTES-1:0] op_b,
   input  logic                            borrow_in,
   output logic                            busy,
   output logic                            done,
   output logic [DATA_WIDTH*NUM_BYTES-1:0] diff,
   output logic                            borrow_out
);

   localparam int              W        = msub_width(DATA_WIDTH, NUM_BYTES);
   localparam int              IDXW     = msub_idx_width(NUM_BYTES);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_BYTES - 1);

   msub_state_e           state_q;
   msub_state_e           state_d;
   logic [W-1:0]          a_q;
   logic [W-1:0]          b_q;
   logic [W-1:0]          diff_q;
   logic [IDXW-1:0]       idx_q;
   logic                  borrow_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  borrow_out_q;

   logic [DATA_WIDTH-1:0] slice_a_w;
   logic [DATA_WIDTH-1:0] slice_b_w;
   logic [DATA_WIDTH-1:0] slice_d_w;
   logic                  slice_borrow_w;
   logic                  last_byte_w;

   // ------------------------------------------------------------------------
   // Operand byte select for the shared slice
   // ------------------------------------------------------------------------
   always_comb begin
      slice_a_w = '0;
      slice_b_w = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (idx_q == IDXW'(k)) begin
            slice_a_w = a_q[k*DATA_WIDTH +: DATA_WIDTH];
            slice_b_w = b_q[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign last_byte_w = (idx_q == IDX_LAST);

   msub_byte_slice #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_slice (
      .a_i      (slice_a_w),
      .b_i      (slice_b_w),
      .borrow_i (borrow_q),
      .diff_o   (slice_d_w),
      .borrow_o (slice_borrow_w)
   );

   // ------------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_byte_w) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Sequencer, datapath registers and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         diff_q       <= '0;
         idx_q        <= '0;
         borrow_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q      <= op_a;
                  b_q      <= op_b;
                  borrow_q <= borrow_in;
                  idx_q    <= '0;
                  diff_q   <= '0;
                  busy_q   <= 1'b1;
               end
            end
            RUN: begin
               for (int k = 0; k < NUM_BYTES; k++) begin
                  if (idx_q == IDXW'(k)) begin
                     diff_q[k*DATA_WIDTH +: DATA_WIDTH] <= slice_d_w;
                  end
               end
               borrow_q <= slice_borrow_w;
               if (last_byte_w) begin
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  borrow_out_q <= slice_borrow_w;
`ifdef MSUB_SATURATE_EN
                  // Later assignment overrides the byte write above.
                  if (slice_borrow_w) begin
                     diff_q <= '0;
                  end
`endif
               end else begin
                  // Index stays on the last byte so a 1-byte build never wraps.
                  idx_q <= idx_q + IDXW'(1);
               end
            end
            default: begin
               // DONE: one-cycle turnaround; results simply hold.
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;

endmodule : multibyte_sub_ctrl
`default_nettype wire

// File: tb/tb_multibyte_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multibyte_sub_ctrl
// Purpose  : Directed self-checking bench for multibyte_sub_ctrl. Drives a
//            4-byte instance and a 1-byte instance with hand-computed vectors.
// Options  : MSUB_SATURATE_EN - expected values follow the clamped result.
// Revision : 1.0  initial release
// ============================================================================
module tb_multibyte_sub_ctrl;

`ifdef MSUB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        borrow_in;
   logic        busy;
   logic        done;
   logic [31:0] diff;
   logic        borrow_out;

   logic        start1;
   logic [7:0]  a1;
   logic [7:0]  b1;
   logic        bin1;
   logic        busy1;
   logic        done1;
   logic [7:0]  diff1;
   logic        bout1;

   int n_checks;
   int n_errors;

   multibyte_sub_ctrl #(
      .DATA_WIDTH (8),
      .NUM_BYTES  (4)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op_a       (op_a),
      .op_b       (op_b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   multibyte_sub_ctrl #(
      .DATA_WIDTH (8),
      .NUM_BYTES  (1)
   ) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start1),
      .op_a       (a1),
      .op_b       (b1),
      .borrow_in  (bin1),
      .busy       (busy1),
      .done       (done1),
      .diff       (diff1),
      .borrow_out (bout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One transaction on the 4-byte instance. Called just after a rising edge
   // with the DUT idle. Scrambles operands and pulses start while running,
   // and raises start during DONE, all of which must be ignored.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic [31:0] exp_d, input logic exp_b);
      int n;
      op_a = a; op_b = b; borrow_in = bin; start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_busy"}, busy, 1);
      n = 0;
      while (!done && n < 20) begin
         op_a      = $urandom;
         op_b      = $urandom;
         borrow_in = ~bin;
         start     = n[0];
         @(posedge clk); #1;
         n++;
      end
      // done is set by the 4th edge after accept: visible in cycle T+5.
      chk({tag, "_lat"}, 64'(n), 64'd4);
      chk({tag, "_diff"}, diff, exp_d);
      chk({tag, "_bout"}, borrow_out, exp_b);
      chk({tag, "_busy_done"}, busy, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_hold"}, diff, exp_d);
   endtask

   task automatic do_op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] exp_d, input logic exp_b);
      int n;
      a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      a1 = 8'hA5; b1 = 8'h3C;
      n = 0;
      while (!done1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'd1);
      chk({tag, "_diff"}, diff1, exp_d);
      chk({tag, "_bout"}, bout1, exp_b);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done1, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pos [3];
      int cnt;
      int dbl;
      logic prev_done;

      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      op_a      = '0;
      op_b      = '0;
      borrow_in = 1'b0;
      start1    = 1'b0;
      a1        = '0;
      b1        = '0;
      bin1      = 1'b0;

      // Reset state
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", borrow_out, 0);
      chk("rst1_diff", diff1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Main function
      do_op("basic",  32'h12345678, 32'h11111111, 1'b0, 32'h01234567, 1'b0);
      do_op("chain",  32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0);
      do_op("binc",   32'h00000010, 32'h00000000, 1'b1, 32'h0000000F, 1'b0);
      do_op("msb",    32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFE, 1'b0);
      do_op("allff",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, SAT ? 32'h0 : 32'hFFFFFFFF, 1'b1);
      do_op("under",  32'h00000000, 32'h00000001, 1'b0, SAT ? 32'h0 : 32'hFFFFFFFF, 1'b1);

      // Asynchronous reset in the middle of a run (borrow_out is 1 here)
      op_a = 32'hAABBCCDD; op_b = 32'h11111111; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_diff", diff, 0);
      chk("mrst_bout", borrow_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op("postrst", 32'h12345678, 32'h11111111, 1'b0, 32'h01234567, 1'b0);

      // start held high: accept every 6 cycles, single-cycle done pulses,
      // operands scrambled whenever busy must not matter
      cnt = 0; dbl = 0; prev_done = 1'b0;
      op_a = 32'h12345678; op_b = 32'h11111111; borrow_in = 1'b0; start = 1'b1;
      for (int e = 1; e <= 18; e++) begin
         @(posedge clk); #1;
         if (done) begin
            if (cnt < 3) pos[cnt] = e;
            cnt++;
            chk("cont_diff", diff, 32'h01234567);
         end
         if (done && prev_done) dbl++;
         prev_done = done;
         if (busy) begin
            op_a = $urandom; op_b = $urandom; borrow_in = 1'b1;
         end else begin
            op_a = 32'h12345678; op_b = 32'h11111111; borrow_in = 1'b0;
         end
      end
      start = 1'b0;
      chk("cont_cnt", 64'(cnt), 64'd3);
      chk("cont_pos0", 64'(pos[0]), 64'd5);
      chk("cont_pos1", 64'(pos[1]), 64'd11);
      chk("cont_pos2", 64'(pos[2]), 64'd17);
      chk("cont_dbl", 64'(dbl), 64'd0);

      // Single-byte instance
      do_op1("nb1_under", 8'h05, 8'h07, 1'b0, SAT ? 8'h00 : 8'hFE, 1'b1);
      do_op1("nb1_pos",   8'h07, 8'h05, 1'b1, 8'h01, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_multibyte_sub_ctrl
`default_nettype wire
